// File: rtl/la_pkg.sv
// Shared types and default widths for the logic-analyser capture path.
package la_pkg;

    localparam int LA_SAMPLE_WIDTH = 8;
    localparam int LA_ADDR_WIDTH   = 12;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        POST,
        DONE
    } capture_state_t;

endpackage

// File: rtl/capture_trigger_match.sv
// Latched trigger configuration and masked level-plus-edge match.
module trigger_match
    import la_pkg::*;
#(
    parameter int SAMPLE_WIDTH = LA_SAMPLE_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [SAMPLE_WIDTH-1:0] trigMask,
    input  logic [SAMPLE_WIDTH-1:0] trigValue,
    input  logic [SAMPLE_WIDTH-1:0] edgeMask,
    input  logic                    sampleEn,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    hit
);

    logic [SAMPLE_WIDTH-1:0] maskQ;
    logic [SAMPLE_WIDTH-1:0] valueQ;
    logic [SAMPLE_WIDTH-1:0] edgeQ;
    logic [SAMPLE_WIDTH-1:0] prev;
    logic                    prevValid;
    logic                    levelOk;
    logic                    edgeOk;

    always_ff @(posedge clock) begin
        if (reset) begin
            maskQ     <= '0;
            valueQ    <= '0;
            edgeQ     <= '0;
            prev      <= '0;
            prevValid <= 1'b0;
        end else if (load) begin
            maskQ     <= trigMask;
            valueQ    <= trigValue;
            edgeQ     <= edgeMask;
            prevValid <= 1'b0;
        end else if (sampleEn) begin
            prev      <= sample;
            prevValid <= 1'b1;
        end
    end

    assign levelOk = ((sample ^ valueQ) & maskQ) == '0;
    // No history yet means no edge can be seen on any selected bit.
    assign edgeOk  = (edgeQ == '0) ||
                     (prevValid && (((sample ^ prev) & edgeQ) != '0));
    assign hit     = levelOk && edgeOk;

endmodule

// File: rtl/capture_trigger.sv
// Trigger FSM, ring write address and post-trigger counter.
module capture_trigger
    import la_pkg::*;
#(
    parameter int SAMPLE_WIDTH = LA_SAMPLE_WIDTH,
    parameter int ADDR_WIDTH   = LA_ADDR_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [SAMPLE_WIDTH-1:0] dataIn,
    input  logic                    validIn,
    input  logic [SAMPLE_WIDTH-1:0] trigMask,
    input  logic [SAMPLE_WIDTH-1:0] trigValue,
    input  logic [SAMPLE_WIDTH-1:0] edgeMask,
    input  logic [ADDR_WIDTH-1:0]   postCount,
    output logic                    wrEn,
    output logic [ADDR_WIDTH-1:0]   wrAddr,
    output logic [SAMPLE_WIDTH-1:0] wrData,
    output logic                    triggered,
    output logic [ADDR_WIDTH-1:0]   trigAddr,
    output logic                    done,
    output logic                    busy
);

    capture_state_t        state;
    logic [ADDR_WIDTH-1:0] addrPtr;
    logic [ADDR_WIDTH-1:0] postLat;
    logic [ADDR_WIDTH-1:0] postLeft;
    logic                  capturing;
    logic                  accept;
    logic                  sampleEn;
    logic                  hit;

    assign capturing = (state == ARMED) || (state == POST);
    assign accept    = arm && !abort &&
                       ((state == IDLE) || (state == DONE));
    assign sampleEn  = validIn && !abort && capturing;

    trigger_match #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH)
    ) u_match (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .trigMask (trigMask),
        .trigValue(trigValue),
        .edgeMask (edgeMask),
        .sampleEn (sampleEn),
        .sample   (dataIn),
        .hit      (hit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wrEn      <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            triggered <= 1'b0;
            trigAddr  <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            addrPtr   <= '0;
            postLat   <= '0;
            postLeft  <= '0;
        end else begin
            wrEn <= 1'b0;
            if (abort) begin
                state <= IDLE;
                done  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (arm) begin
                            state     <= ARMED;
                            postLat   <= postCount;
                            wrAddr    <= '0;
                            addrPtr   <= '0;
                            triggered <= 1'b0;
                            done      <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    ARMED, POST: begin
                        if (validIn) begin
                            wrEn    <= 1'b1;
                            wrData  <= dataIn;
                            wrAddr  <= addrPtr;
                            addrPtr <= addrPtr + ADDR_WIDTH'(1);
                            if (state == ARMED) begin
                                if (hit) begin
                                    triggered <= 1'b1;
                                    trigAddr  <= addrPtr;
                                    postLeft  <= postLat;
                                    if (postLat == '0) begin
                                        state <= DONE;
                                        done  <= 1'b1;
                                        busy  <= 1'b0;
                                    end else begin
                                        state <= POST;
                                    end
                                end
                            end else begin
                                // Last post sample closes the capture.
                                postLeft <= postLeft - ADDR_WIDTH'(1);
                                if (postLeft == ADDR_WIDTH'(1)) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_trigger.sv
// Self-checking bench for capture_trigger on a 16-entry ring.
module tb_capture_trigger;

    localparam int SW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] dataIn = '0;
    logic          validIn = 1'b0;
    logic [SW-1:0] trigMask = '0;
    logic [SW-1:0] trigValue = '0;
    logic [SW-1:0] edgeMask = '0;
    logic [AW-1:0] postCount = '0;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [SW-1:0] wrData;
    logic          triggered;
    logic [AW-1:0] trigAddr;
    logic          done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    capture_trigger #(
        .SAMPLE_WIDTH(SW),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .arm      (arm),
        .abort    (abort),
        .dataIn   (dataIn),
        .validIn  (validIn),
        .trigMask (trigMask),
        .trigValue(trigValue),
        .edgeMask (edgeMask),
        .postCount(postCount),
        .wrEn     (wrEn),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .triggered(triggered),
        .trigAddr (trigAddr),
        .done     (done),
        .busy     (busy)
    );

    // Reference model: capture session described by flags and integers.
    bit        m_cap, m_inPost, m_havePrev;
    int        m_next, m_left, m_prev;
    int        c_mask, c_val, c_edge, c_post;
    bit        e_wrEn, e_trig, e_done, e_busy;
    int        e_wrAddr, e_wrData, e_trigAddr;

    task automatic model_finish();
        m_cap = 0;
        m_inPost = 0;
        e_done = 1;
        e_busy = 0;
    endtask

    task automatic model_update();
        int  d;
        bit  lvl, edg;
        d = int'(dataIn);
        if (reset) begin
            m_cap = 0; m_inPost = 0; m_havePrev = 0;
            m_next = 0; m_left = 0; m_prev = 0;
            c_mask = 0; c_val = 0; c_edge = 0; c_post = 0;
            e_wrEn = 0; e_trig = 0; e_done = 0; e_busy = 0;
            e_wrAddr = 0; e_wrData = 0; e_trigAddr = 0;
        end else begin
            e_wrEn = 0;
            if (abort) begin
                m_cap = 0; m_inPost = 0;
                e_done = 0; e_busy = 0;
            end else if (!m_cap) begin
                if (arm) begin
                    c_mask = int'(trigMask); c_val = int'(trigValue);
                    c_edge = int'(edgeMask); c_post = int'(postCount);
                    m_cap = 1; m_inPost = 0; m_havePrev = 0;
                    m_next = 0; e_wrAddr = 0;
                    e_trig = 0; e_done = 0; e_busy = 1;
                end
            end else if (validIn) begin
                e_wrEn = 1;
                e_wrData = d;
                e_wrAddr = m_next;
                m_next = (m_next + 1) % DEPTH;
                if (!m_inPost) begin
                    lvl = ((d ^ c_val) & c_mask) == 0;
                    edg = (c_edge == 0) ||
                          (m_havePrev && (((d ^ m_prev) & c_edge) != 0));
                    if (lvl && edg) begin
                        e_trig = 1;
                        e_trigAddr = e_wrAddr;
                        m_left = c_post;
                        if (m_left == 0) model_finish();
                        else m_inPost = 1;
                    end
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) model_finish();
                end
                m_prev = d;
                m_havePrev = 1;
            end
        end
    endtask

    task automatic compare_model();
        checks++;
        if (wrEn !== e_wrEn || int'(wrAddr) != e_wrAddr ||
            int'(wrData) != e_wrData || triggered !== e_trig ||
            int'(trigAddr) != e_trigAddr || done !== e_done ||
            busy !== e_busy) begin
            errors++;
            $display("FAIL model @%0t: got en=%0b a=%0d d=%0h t=%0b ta=%0d dn=%0b b=%0b expected en=%0b a=%0d d=%0h t=%0b ta=%0d dn=%0b b=%0b",
                     $time, wrEn, wrAddr, wrData, triggered, trigAddr, done, busy,
                     e_wrEn, e_wrAddr, e_wrData, e_trig, e_trigAddr, e_done, e_busy);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic cyc(input bit a, input bit ab, input bit v, input int d);
        arm = a;
        abort = ab;
        validIn = v;
        dataIn = SW'(d);
        step();
    endtask

    task automatic cfg(input int m, input int val, input int e, input int p);
        trigMask = SW'(m);
        trigValue = SW'(val);
        edgeMask = SW'(e);
        postCount = AW'(p);
    endtask

    typedef struct {
        bit a;
        bit v;
        int d;
        bit eEn;
        int eAddr;
        bit eTrig;
        int eTA;
        bit eDone;
        bit eBusy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1, 0, 'h00, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{0, 1, 'h00, 1, 0, 0, 0, 0, 1};
        tbl[2] = '{0, 1, 'h11, 1, 1, 0, 0, 0, 1};
        tbl[3] = '{0, 1, 'hA5, 1, 2, 1, 2, 0, 1};
        tbl[4] = '{0, 1, 'h01, 1, 3, 1, 2, 0, 1};
        tbl[5] = '{0, 1, 'h02, 1, 4, 1, 2, 0, 1};
        tbl[6] = '{0, 1, 'h03, 1, 5, 1, 2, 1, 0};
        tbl[7] = '{0, 1, 'h04, 0, 5, 1, 2, 1, 0};

        reset = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 'h33);
        chk("reset_wrEn", int'(wrEn), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;

        // Level trigger
        cfg('hFF, 'hA5, 0, 3);
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].a, 0, tbl[i].v, tbl[i].d);
            chk($sformatf("lvl%0d_wrEn", i), int'(wrEn), int'(tbl[i].eEn));
            chk($sformatf("lvl%0d_wrAddr", i), int'(wrAddr), tbl[i].eAddr);
            chk($sformatf("lvl%0d_trig", i), int'(triggered), int'(tbl[i].eTrig));
            chk($sformatf("lvl%0d_trigAddr", i), int'(trigAddr), tbl[i].eTA);
            chk($sformatf("lvl%0d_done", i), int'(done), int'(tbl[i].eDone));
            chk($sformatf("lvl%0d_busy", i), int'(busy), int'(tbl[i].eBusy));
        end

        // Edge trigger
        cfg('h01, 'h01, 'h01, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 'h01);
        chk("edge_first", int'(triggered), 0);
        cyc(0, 0, 1, 'h01);
        chk("edge_nochange", int'(triggered), 0);
        cyc(0, 0, 1, 'h00);
        chk("edge_level_miss", int'(triggered), 0);
        cyc(0, 0, 1, 'h01);
        chk("edge_hit", int'(triggered), 1);
        chk("edge_trigAddr", int'(trigAddr), 3);
        cyc(0, 0, 1, 'h05);
        chk("edge_done", int'(done), 1);

        // Wrap
        cfg('hFF, 'h77, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, i);
            chk($sformatf("wrap%0d_addr", i), int'(wrAddr), i % DEPTH);
        end
        chk("wrap_notrig", int'(triggered), 0);
        cyc(0, 0, 1, 'h77);
        chk("wrap_addr", int'(wrAddr), 4);
        chk("wrap_trigAddr", int'(trigAddr), 4);
        chk("wrap_done", int'(done), 1);
        cyc(0, 0, 1, 'h00);
        chk("wrap_nowrite", int'(wrEn), 0);

        // Abort in POST
        cfg('hFF, 'h3C, 0, 5);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 'h3C);
        cyc(0, 0, 1, 'h01);
        cyc(0, 1, 1, 'h02);
        chk("abort_wrEn", int'(wrEn), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_trig", int'(triggered), 1);
        chk("abort_wrAddr", int'(wrAddr), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 'h40 + i);
            chk("abort_idle_wrEn", int'(wrEn), 0);
        end

        // Reset mid-ARMED
        cfg('hFF, 'hFF, 0, 2);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 'h01);
        cyc(0, 0, 1, 'h02);
        reset = 1'b1;
        cyc(0, 0, 1, 'h03);
        reset = 1'b0;
        chk("rst_wrEn", int'(wrEn), 0);
        chk("rst_wrAddr", int'(wrAddr), 0);
        chk("rst_wrData", int'(wrData), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        // Config latch
        cfg('hFF, 'h10, 0, 0);
        cyc(1, 0, 0, 0);
        trigValue = 8'h20;
        cyc(0, 0, 1, 'h20);
        chk("latch_no20", int'(triggered), 0);
        cyc(0, 0, 1, 'h10);
        chk("latch_hit10", int'(triggered), 1);
        chk("latch_trigAddr", int'(trigAddr), 1);
        chk("latch_done", int'(done), 1);

        // Re-arm from DONE with a concurrent sample
        cyc(1, 0, 1, 'h10);
        chk("rearm_wrEn", int'(wrEn), 0);
        chk("rearm_trig", int'(triggered), 0);
        chk("rearm_done", int'(done), 0);
        chk("rearm_wrAddr", int'(wrAddr), 0);
        chk("rearm_busy", int'(busy), 1);
        cyc(0, 0, 1, 'h55);
        chk("rearm_first_addr", int'(wrAddr), 0);
        chk("rearm_first_data", int'(wrData), 'h55);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cfg($urandom_range(0, 7), $urandom_range(0, 255),
                ($urandom_range(0, 1) != 0) ? (1 << $urandom_range(0, 2)) : 0,
                $urandom_range(0, 15));
            reset = ($urandom_range(0, 299) == 0);
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 9) < 6, $urandom_range(0, 7));
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_trigger.md
Name: capture_trigger

Overview:
- Sits directly downstream of the sampler stage and consumes its decimated sample stream (`dataOut`/`validOut`).
- Evaluates a masked level-plus-edge trigger condition on every valid sample.
- Writes samples continuously into a circular capture RAM: pre-trigger history while armed, then a programmable number of post-trigger samples.
- Reports the trigger address and completion to the host-side readout logic.

Parameters:
- `SAMPLE_WIDTH`, 8: width of one sample; matches the sampler stage.
- `ADDR_WIDTH`, 12: capture RAM address width; ring depth = 2^`ADDR_WIDTH`.

Ports:
- `clock`  in  1  single design clock.
- `reset`  in  1  synchronous, active-high reset.
- `arm`  in  1  one-cycle request to start a capture; accepted only in IDLE or DONE.
- `abort`  in  1  forces return to IDLE from any state.
- `dataIn`  in  `SAMPLE_WIDTH`  sample from the sampler stage.
- `validIn`  in  1  sample qualifier from the sampler stage.
- `trigMask`  in  `SAMPLE_WIDTH`  bits that take part in the level compare.
- `trigValue`  in  `SAMPLE_WIDTH`  required level on masked bits.
- `edgeMask`  in  `SAMPLE_WIDTH`  bits that must change versus the previous valid sample.
- `postCount`  in  `ADDR_WIDTH`  number of samples written after the trigger sample.
- `wrEn`  out  1  capture RAM write strobe.
- `wrAddr`  out  `ADDR_WIDTH`  capture RAM write address.
- `wrData`  out  `SAMPLE_WIDTH`  capture RAM write data.
- `triggered`  out  1  high from the trigger write until the next arm accept or reset.
- `trigAddr`  out  `ADDR_WIDTH`  address at which the trigger sample was written.
- `done`  out  1  high in DONE.
- `busy`  out  1  high in ARMED or POST.

Behaviour:
- **Reset** (sync, `reset`=1):
  - state=IDLE.
  - `wrEn`=0, `wrAddr`=0, `wrData`=0, `trigAddr`=0.
  - `triggered`=0, `done`=0, `busy`=0.
  - prevValid=0; latched config registers=0.
- **Reset mid-capture:** identical result; any partial capture is discarded.
- **States:** IDLE, ARMED, POST, DONE.
- **Arm accept** (IDLE or DONE with `arm`=1):
  - Latch `trigMask`, `trigValue`, `edgeMask`, `postCount`; later input changes are ignored until the next accept.
  - Clear `wrAddr` to 0, `triggered` to 0, `done` to 0, and prevValid to 0.
  - Next state is ARMED.
  - `arm` in ARMED or POST is ignored.
- **Write path:** in ARMED or POST, every cycle with `validIn`=1 produces, on the next clock edge:
  - `wrEn`=1 and `wrData`=`dataIn`;
  - `wrAddr` = the address of that write, advancing by 1 after each write.
  - `wrEn` is a one-cycle pulse per sample; latency is exactly 1 cycle.
  - The address wraps from 2^`ADDR_WIDTH`-1 to 0 with no status change.
  - No writes occur in IDLE or DONE.
- **Trigger condition:** evaluated on a valid sample S in ARMED only.
  - level = ((S ^ `trigValue`) & `trigMask`) == 0.
  - edge = (`edgeMask` == 0) OR (prevValid AND ((S ^ prev) & `edgeMask`) != 0).
  - trigger = level AND edge.
  - prev and prevValid update on every valid sample in ARMED or POST.
  - The first sample after arm can never satisfy a non-zero `edgeMask`.
- **ARMED → POST:** when a triggering sample is written:
  - `trigAddr` = that sample's address;
  - `triggered`=1, in the same cycle as its `wrEn`;
  - the post counter is loaded with the latched `postCount`.
  - If `postCount`=0, go directly to DONE after the trigger write.
- **POST:** each subsequent valid sample is written and decrements the counter. The write that takes the counter to 0 moves the state to DONE. Exactly `postCount` samples follow the trigger sample.
- **DONE:** `done`=1 and `busy`=0. `trigAddr` and `triggered` are held until the next arm accept.
- **abort:** in any state, next state is IDLE.
  - `wrEn` is forced to 0 that cycle.
  - `triggered`, `trigAddr` and `wrAddr` are held.
  - `done`=0.
- **Simultaneous events:**
  - `reset` beats `abort`; `abort` beats `arm`.
  - `arm` together with `validIn` in IDLE/DONE: that sample is not written.
- **Long captures:** if `postCount` ≥ ring depth, pre-trigger data and the trigger sample are overwritten. This is permitted; no flag is raised.
- **Widths:** all address and counter arithmetic is modulo 2^`ADDR_WIDTH`; no saturation.

Decomposition:
- Shared package `la_pkg`:
  - typedef `capture_state_t` (IDLE, ARMED, POST, DONE);
  - localparam default widths `LA_SAMPLE_WIDTH`=8 and `LA_ADDR_WIDTH`=12.
- One sub-module, `trigger_match`:
  - holds the latched mask/value/edge registers, prev and prevValid;
  - outputs a combinational hit for the current sample.
- The FSM, address and post counter stay in `capture_trigger`.

Test Plan:
- **Level trigger:** `trigMask`=0xFF, `trigValue`=0xA5, `edgeMask`=0, `postCount`=3; arm, then valid samples 0x00, 0x11, 0xA5, 0x01, 0x02, 0x03, 0x04.
  - Writes at addresses 0..5; `trigAddr`=2; `triggered` rises with write 2.
  - `done` after address 5; 0x04 is not written.
- **Edge trigger:** `trigMask`=0x01, `trigValue`=0x01, `edgeMask`=0x01; samples 0x01, 0x01, 0x00, 0x01.
  - The first sample does not trigger (prevValid=0); the second does not (no change).
  - Trigger on the fourth sample, `trigAddr`=3.
- **Wrap:** `ADDR_WIDTH`=4; 20 non-matching samples, then a match with `postCount`=0.
  - `wrAddr` sequence 0..15, 0..3; trigger written at 4; `trigAddr`=4; DONE next cycle.
- **Abort/reset:** abort in POST after 1 of 5 post samples → IDLE, `done`=0, no further `wrEn`. Reset mid-ARMED → all outputs 0 next cycle.
- **Config latch:** arm with `trigValue`=0x10, then change the input to 0x20 before 0x20 arrives → no trigger on 0x20; trigger on a later 0x10.
- **Re-arm:** re-arm from DONE with `arm` and `validIn` in the same cycle → that sample is not written; `triggered` and `done` clear; `wrAddr` restarts at 0.
